double_to_long: RTL and testbench



---
 rtl/double_to_long.sv | 136 +++++++++++++
 tb/tb_double_to_long.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/double_to_long.sv
// double_to_long: iterative IEEE-754 double to signed 64-bit integer.
// Ports: clk, rst_n, input_a/_stb/_ack (in), output_z/_stb/_ack (out).
module double_to_long (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [63:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [2:0] {
    GET_A,
    UNPACK,
    SHIFT,
    NEGATE,
    PUT_Z
  } state_t;

  localparam logic [63:0] MIN_LONG = 64'h8000_0000_0000_0000;

  state_t      state_q, state_d;
  logic [63:0] a_q, a_d;
  logic [63:0] m_q, m_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic [63:0] z_q, z_d;
  logic        zstb_q, zstb_d;
  logic        aack_q, aack_d;

  logic signed [11:0] e;
  logic               under;
  logic               over;

  // Unbiased exponent of the held operand, plus the two
  // range classes that bypass the shifter.
  assign e     = $signed({1'b0, a_q[62:52]}) - 12'sd1023;
  assign under = e < 12'sd0;
  assign over  = e >= 12'sd63;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GET_A;
      a_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      z_q     <= '0;
      zstb_q  <= 1'b0;
      aack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      z_q     <= z_d;
      zstb_q  <= zstb_d;
      aack_q  <= aack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    z_d     = z_q;
    zstb_d  = zstb_q;
    aack_d  = aack_q;

    unique case (state_q)
      GET_A: begin
        aack_d = 1'b1;
        if (aack_q && input_a_stb) begin
          a_d     = input_a;
          aack_d  = 1'b0;
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        sign_d = a_q[63];
        m_d    = {1'b1, a_q[51:0], 11'b0};
        // Only meaningful when 0 <= e <= 62, giving 1..63.
        cnt_d  = 6'd63 - e[5:0];
        if (under) begin
          z_d     = '0;
          zstb_d  = 1'b1;
          state_d = PUT_Z;
        end else if (over) begin
          z_d     = MIN_LONG;
          zstb_d  = 1'b1;
          state_d = PUT_Z;
        end else begin
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt_q != 6'd0) begin
          m_d   = m_q >> 1;
          cnt_d = cnt_q - 6'd1;
        end else begin
          state_d = NEGATE;
        end
      end

      NEGATE: begin
        z_d     = sign_q ? (~m_q + 64'd1) : m_q;
        zstb_d  = 1'b1;
        state_d = PUT_Z;
      end

      PUT_Z: begin
        if (output_z_ack) begin
          zstb_d  = 1'b0;
          aack_d  = 1'b1;
          state_d = GET_A;
        end
      end

      default: begin
        state_d = GET_A;
      end
    endcase
  end

  assign input_a_ack  = aack_q;
  assign output_z     = z_q;
  assign output_z_stb = zstb_q;

endmodule

// File: tb/tb_double_to_long.sv
// tb_double_to_long: randomized self-checking bench for double_to_long.
// Compares result and latency against an arithmetic reference model.
module tb_double_to_long;

  logic        clk;
  logic        rst_n;
  logic [63:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [63:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int n_chk;
  int n_fail;

  double_to_long dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_conv(input logic [63:0] a);
    int          be;
    int          e;
    logic [63:0] man;
    logic [63:0] mag;
    be  = int'(a[62:52]);
    e   = be - 1023;
    man = {11'b0, 1'b1, a[51:0]};
    if (be < 1023) return 64'd0;
    if (e >= 63) return 64'h8000_0000_0000_0000;
    if (e >= 52) mag = man << (e - 52);
    else         mag = man >> (52 - e);
    return a[63] ? (64'd0 - mag) : mag;
  endfunction

  function automatic int ref_lat(input logic [63:0] a);
    int e;
    e = int'(a[62:52]) - 1023;
    if (e < 0 || e >= 63) return 1;
    return (63 - e) + 3;
  endfunction

  task automatic run_op(input string tag,
                        input logic [63:0] a,
                        input int hold);
    int          w;
    int          edges;
    logic        stable;
    logic [63:0] exp;
    exp = ref_conv(a);
    w = 0;
    while (!input_a_ack && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk({tag, "_rdy"}, {63'd0, input_a_ack}, 64'd1);
    input_a     = a;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_ackdrop"}, {63'd0, input_a_ack}, 64'd0);
    // Garbage on the input while busy must be ignored.
    input_a = ~a;
    edges = 0;
    while (!output_z_stb && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, "_lat"}, 64'(edges), 64'(ref_lat(a)));
    chk({tag, "_z"}, output_z, exp);
    input_a_stb = 1'b0;
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (output_z !== exp || output_z_stb !== 1'b1 ||
            input_a_ack !== 1'b0)
          stable = 1'b0;
      end
      chk({tag, "_hold"}, {63'd0, stable}, 64'd1);
    end
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    chk({tag, "_stbclr"}, {63'd0, output_z_stb}, 64'd0);
    chk({tag, "_rearm"}, {63'd0, input_a_ack}, 64'd1);
  endtask

  initial begin
    logic [63:0] a;
    logic        seen;
    int          e;
    n_chk        = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    input_a      = '0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_z", output_z, 64'd0);
    chk("rst_stb", {63'd0, output_z_stb}, 64'd0);
    chk("rst_ack", {63'd0, input_a_ack}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ack", {63'd0, input_a_ack}, 64'd1);

    run_op("one",   64'h3FF0_0000_0000_0000, 0);
    run_op("p62",   64'h43D0_0000_0000_0000, 0);
    run_op("m3",    64'hC008_0000_0000_0000, 0);
    run_op("p2_5",  64'h4004_0000_0000_0000, 0);
    run_op("half",  64'h3FE0_0000_0000_0000, 0);
    run_op("nan",   64'h7FF8_0000_0000_0000, 0);
    run_op("pinf",  64'h7FF0_0000_0000_0000, 0);
    run_op("m2_63", 64'hC3E0_0000_0000_0000, 0);
    run_op("zero",  64'h0000_0000_0000_0000, 0);
    run_op("bp",    64'hC008_0000_0000_0000, 20);

    // Reset in the middle of the shift loop.
    while (!input_a_ack) begin
      @(posedge clk); #1;
    end
    input_a     = 64'h3FF0_0000_0000_0000;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_z", output_z, 64'd0);
    chk("mid_rst_stb", {63'd0, output_z_stb}, 64'd0);
    chk("mid_rst_ack", {63'd0, input_a_ack}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (output_z_stb) seen = 1'b1;
    end
    chk("mid_rst_nostb", {63'd0, seen}, 64'd0);
    run_op("m4", 64'hC010_0000_0000_0000, 0);

    // Back-to-back floor-style operands.
    for (int i = 0; i < 40; i++) begin
      a[63]    = 1'($urandom_range(0, 1));
      a[62:52] = 11'($urandom_range(1016, 1090));
      a[51:0]  = {20'($urandom), 32'($urandom)};
      e = int'(a[62:52]) - 1023;
      if (e >= 0 && e < 52)
        a[51:0] = a[51:0] & ~((52'd1 << (52 - e)) - 52'd1);
      if ($urandom_range(0, 9) == 0)
        a[62:52] = 11'h7FF;
      run_op("rnd", a, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
